// File: rtl/psg_bus_bridge_if.sv
// CPU-side register bus of the PSG bridge: write/read strobes in, read data and status out.
interface psg_bus_bridge_if;
  logic       address;
  logic [7:0] data;
  logic       wren;
  logic       rden;
  logic [7:0] q;
  logic       busy;
  logic       overflow;

  modport master (output address, data, wren, rden, input q, busy, overflow);
  modport slave  (input address, data, wren, rden, output q, busy, overflow);
endinterface

// File: rtl/psg_bus_bridge.sv
// Queues CPU writes and replays them as AY-style bus cycles to NUM_CHIPS PSG cores, and mixes their audio.
// Optional register readback is compiled in with macro PSG_BRIDGE_READBACK_EN.
module psg_bus_bridge #(
  parameter int NUM_CHIPS  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int SOUND_W    = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ce,
  psg_bus_bridge_if.slave        bus,
  output logic [7:0]             psg_da,
  output logic [NUM_CHIPS-1:0]   psg_bdir,
  output logic [NUM_CHIPS-1:0]   psg_bc2,
  output logic [NUM_CHIPS-1:0]   psg_bc1,
  input  logic [8*NUM_CHIPS-1:0] psg_q,
  input  logic [NUM_CHIPS-1:0]   psg_q_oe_l,
  input  logic [8*NUM_CHIPS-1:0] psg_sound,
  output logic [SOUND_W-1:0]     sound
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SEL_W = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
  localparam logic [7:0]  CS_BASE   = 8'(256 - NUM_CHIPS);
  localparam logic [12:0] SOUND_MAX = 13'((1 << SOUND_W) - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         q_q, q_d;
  logic [SOUND_W-1:0] sound_q, sound_d;
  logic               ent_addr_q, ent_addr_d;
  logic [7:0]         ent_data_q, ent_data_d;

  // Entry layout: bit 8 = address-port flag, bits 7:0 = data byte.
  logic [8:0] fifo_mem [FIFO_DEPTH];

  logic       fifo_full, fifo_empty;
  logic       push, pop;
  logic [8:0] head;
  logic [7:0] head_inv;
  logic       head_is_cs;
  logic       rd_fire;
  logic [7:0] rd_data;
  logic       rd_oe_l;
  logic [12:0] mix_sum;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem[rd_ptr_q];
  assign head_inv   = ~head[7:0];
  assign head_is_cs = head[8] && (head[7:0] >= CS_BASE);
  assign pop        = (state_q == ST_IDLE) && !fifo_empty && ce;
  // A full queue still accepts a write when the head leaves on the same edge.
  assign push       = bus.wren && (!fifo_full || pop);

`ifdef PSG_BRIDGE_READBACK_EN
  assign rd_fire = reset_n && bus.rden && (state_q == ST_IDLE) && fifo_empty;
`else
  logic unused_readback;
  assign unused_readback = ^{bus.rden, psg_q, psg_q_oe_l};
  assign rd_fire = 1'b0;
`endif

  always_comb begin
    rd_data = 8'hFF;
    rd_oe_l = 1'b1;
`ifdef PSG_BRIDGE_READBACK_EN
    for (int i = 0; i < NUM_CHIPS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        rd_data = psg_q[8*i +: 8];
        rd_oe_l = psg_q_oe_l[i];
      end
    end
`endif
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      mix_sum = mix_sum + 13'(psg_sound[8*i +: 8]);
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sel_d      = sel_q;
    ovf_d      = ovf_q | (bus.wren && !push);
    q_d        = q_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    sound_d    = (mix_sum > SOUND_MAX) ? SOUND_MAX[SOUND_W-1:0] : mix_sum[SOUND_W-1:0];

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if (head_is_cs) begin
            sel_d = head_inv[SEL_W-1:0];
          end else begin
            ent_addr_d = head[8];
            ent_data_d = head[7:0];
            state_d    = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: if (ce) state_d = ST_GAP;
      ST_GAP:   if (ce) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (rd_fire && !rd_oe_l) q_d = rd_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sel_q      <= '0;
      ovf_q      <= 1'b0;
      q_q        <= 8'hFF;
      sound_q    <= '0;
      ent_addr_q <= 1'b0;
      ent_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sel_q      <= sel_d;
      ovf_q      <= ovf_d;
      q_q        <= q_d;
      sound_q    <= sound_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
    end
  end

  // Queue storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (reset_n && push) fifo_mem[wr_ptr_q] <= {bus.address, bus.data};
  end

  assign psg_da       = (state_q == ST_DRIVE) ? ent_data_q : 8'h00;
  assign bus.q        = q_q;
  assign bus.busy     = !fifo_empty || (state_q != ST_IDLE);
  assign bus.overflow = ovf_q;
  assign sound        = sound_q;

  // Address write = 001, data write = 110, register read = 011, on the selected core only.
  generate
    for (genvar gi = 0; gi < NUM_CHIPS; gi++) begin : g_ctl
      logic chip_hit, drive_on;
      assign chip_hit     = (sel_q == SEL_W'(gi));
      assign drive_on     = chip_hit && (state_q == ST_DRIVE);
      assign psg_bdir[gi] = drive_on && !ent_addr_q;
      assign psg_bc2[gi]  = (drive_on && !ent_addr_q) || (chip_hit && rd_fire);
      assign psg_bc1[gi]  = (drive_on && ent_addr_q) || (chip_hit && rd_fire);
    end
  endgenerate

endmodule

// File: tb/tb_psg_bus_bridge.sv
// Directed bench for psg_bus_bridge: write sequencing, chip select, overflow, readback, mixing and reset.
module tb_psg_bus_bridge;
  localparam int NC = 2;
  localparam int FD = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ce;
  logic [7:0]    psg_da;
  logic [NC-1:0] bdir, bc2, bc1;
  logic [15:0]   psg_q;
  logic [NC-1:0] oe_l;
  logic [15:0]   psg_sound;
  logic [SW-1:0] sound;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit ce_mode = 1'b0;

  always #5 clk = ~clk;

  psg_bus_bridge_if bus_if ();

  psg_bus_bridge #(.NUM_CHIPS(NC), .FIFO_DEPTH(FD), .SOUND_W(SW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .bus        (bus_if),
    .psg_da     (psg_da),
    .psg_bdir   (bdir),
    .psg_bc2    (bc2),
    .psg_bc1    (bc1),
    .psg_q      (psg_q),
    .psg_q_oe_l (oe_l),
    .psg_sound  (psg_sound),
    .sound      (sound)
  );

  function automatic logic [2:0] ctl(input int c);
    return {bdir[c], bc2[c], bc1[c]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ce_mode) ce = ((cyc % 8) == 0);
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    bus_if.address = a;
    bus_if.data    = d;
    bus_if.wren    = 1'b1;
    tick();
    bus_if.wren    = 1'b0;
    $display("write port=%0d data=%02h busy=%0b overflow=%0b", a, d, bus_if.busy, bus_if.overflow);
  endtask

  initial begin
    int npulse;
    int ctl0_seen;
    bit in_pulse;

    reset_n = 1'b0; ce = 1'b1;
    bus_if.address = 1'b0; bus_if.data = 8'h00; bus_if.wren = 1'b0; bus_if.rden = 1'b0;
    psg_q = {8'h11, 8'h5A}; oe_l = 2'b00; psg_sound = 16'h0000;
    tick(); tick();
    chk("rst_q", bus_if.q, 8'hFF);
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_ovf", bus_if.overflow, 1'b0);
    chk("rst_da", psg_da, 8'h00);
    chk("rst_ctl0", ctl(0), 3'b000);
    chk("rst_ctl1", ctl(1), 3'b000);
    chk("rst_sound", sound, 8'h00);
    reset_n = 1'b1;
    tick();

    // Address 07 then data 38 with ce held high.
    wr(1'b1, 8'h07);
    chk("t1_busy_q", bus_if.busy, 1'b1);
    chk("t1_nodrive_yet", ctl(0), 3'b000);
    wr(1'b0, 8'h38);
    chk("t1_addr_ctl0", ctl(0), 3'b001);
    chk("t1_addr_da", psg_da, 8'h07);
    chk("t1_addr_ctl1", ctl(1), 3'b000);
    tick();
    chk("t1_gap_ctl0", ctl(0), 3'b000);
    chk("t1_gap_da", psg_da, 8'h00);
    tick();
    chk("t1_idle_ctl0", ctl(0), 3'b000);
    tick();
    chk("t1_data_ctl0", ctl(0), 3'b110);
    chk("t1_data_da", psg_da, 8'h38);
    tick();
    chk("t1_gap2_busy", bus_if.busy, 1'b1);
    tick();
    chk("t1_done_busy", bus_if.busy, 1'b0);

    // Select chip1, then address 08 / data 0F go to chip1 only.
    wr(1'b1, 8'hFE);
    wr(1'b1, 8'h08);
    chk("t2_cs_ctl0", ctl(0), 3'b000);
    chk("t2_cs_ctl1", ctl(1), 3'b000);
    wr(1'b0, 8'h0F);
    chk("t2_addr_ctl1", ctl(1), 3'b001);
    chk("t2_addr_da", psg_da, 8'h08);
    ctl0_seen = (ctl(0) != 3'b000) ? 1 : 0;
    npulse = 0;
    in_pulse = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ctl(0) != 3'b000) ctl0_seen++;
      if (ctl(1) == 3'b110 && !in_pulse) begin
        npulse++;
        chk("t2_data_da", psg_da, 8'h0F);
      end
      in_pulse = (ctl(1) == 3'b110);
    end
    chk("t2_chip0_quiet", ctl0_seen, 0);
    chk("t2_chip1_pulses", npulse, 1);
    chk("t2_busy_end", bus_if.busy, 1'b0);

    // Back to chip0, then five writes against a 1-in-8 ce.
    wr(1'b1, 8'hFF);
    tick(); tick(); tick();
    chk("t3_pre_busy", bus_if.busy, 1'b0);
    ce_mode = 1'b1; cyc = 0; ce = 1'b0;
    for (int k = 1; k <= 5; k++) wr(1'b0, 8'(8'hA0 + k));
    chk("t3_ovf", bus_if.overflow, 1'b1);
    chk("t3_busy", bus_if.busy, 1'b1);
    npulse = 0;
    in_pulse = 1'b0;
    while (cyc < 110) begin
      tick();
      if (ctl(0) == 3'b110 && !in_pulse) begin
        npulse++;
        chk("t3_order_da", psg_da, 8'(8'hA0 + npulse));
      end
      in_pulse = (ctl(0) == 3'b110);
      if (cyc == 16) chk("t3_hold_drive", ctl(0), 3'b110);
      if (cyc == 17) chk("t3_gap_entered", ctl(0), 3'b000);
      if (cyc == 96) chk("t3_busy_lastgap", bus_if.busy, 1'b1);
      if (cyc == 97) chk("t3_busy_fall", bus_if.busy, 1'b0);
    end
    chk("t3_pulses", npulse, 4);
    chk("t3_ovf_sticky", bus_if.overflow, 1'b1);
    ce_mode = 1'b0; ce = 1'b1;

    // Readback on chip0.
`ifdef PSG_BRIDGE_READBACK_EN
    psg_q = {8'h11, 8'h5A}; oe_l = 2'b00;
    bus_if.rden = 1'b1;
    #1;
    chk("t4_rd_ctl0", ctl(0), 3'b011);
    chk("t4_rd_ctl1", ctl(1), 3'b000);
    tick();
    bus_if.rden = 1'b0;
    chk("t4_rd_q", bus_if.q, 8'h5A);
    $display("read q=%02h", bus_if.q);
    psg_q[7:0] = 8'h33; oe_l = 2'b01;
    bus_if.rden = 1'b1;
    tick();
    bus_if.rden = 1'b0;
    chk("t4_oe_hold", bus_if.q, 8'h5A);
    oe_l = 2'b00;
    wr(1'b0, 8'h44);
    psg_q[7:0] = 8'h77;
    bus_if.rden = 1'b1;
    #1;
    chk("t4_busy_noread", ctl(0), 3'b000);
    tick();
    bus_if.rden = 1'b0;
    chk("t4_busy_qhold", bus_if.q, 8'h5A);
    tick(); tick(); tick();
    chk("t4_busy_end", bus_if.busy, 1'b0);
`else
    psg_q = {8'h11, 8'h5A}; oe_l = 2'b00;
    bus_if.rden = 1'b1;
    #1;
    chk("t4_nord_ctl0", ctl(0), 3'b000);
    tick();
    bus_if.rden = 1'b0;
    chk("t4_nord_q", bus_if.q, 8'hFF);
    $display("read q=%02h", bus_if.q);
`endif

    // Audio mix with 8-bit saturation.
    psg_sound = {8'h80, 8'hC0}; tick();
    chk("t5_sat", sound, 8'hFF);
    psg_sound = {8'h20, 8'h10}; tick();
    chk("t5_sum", sound, 8'h30);
    psg_sound = {8'h80, 8'h7E}; tick();
    chk("t5_edge", sound, 8'hFE);

    // Reset while a write is being driven and another is queued.
    ce = 1'b1;
    wr(1'b0, 8'h55);
    wr(1'b0, 8'h66);
    ce = 1'b0;
    chk("t6_drive_ctl0", ctl(0), 3'b110);
    chk("t6_drive_da", psg_da, 8'h55);
    reset_n = 1'b0;
    bus_if.wren = 1'b1; bus_if.rden = 1'b1; bus_if.data = 8'h99;
    tick();
    chk("t6_rst_ctl0", ctl(0), 3'b000);
    chk("t6_rst_da", psg_da, 8'h00);
    chk("t6_rst_busy", bus_if.busy, 1'b0);
    chk("t6_rst_ovf", bus_if.overflow, 1'b0);
    chk("t6_rst_q", bus_if.q, 8'hFF);
    chk("t6_rst_sound", sound, 8'h00);
    tick();
    chk("t6_rst_wren_ign", bus_if.busy, 1'b0);
    reset_n = 1'b1; bus_if.wren = 1'b0; bus_if.rden = 1'b0; ce = 1'b1;
    tick();
    chk("t6_discarded", bus_if.busy, 1'b0);

    // Push and pop together while full.
    ce = 1'b0;
    for (int k = 1; k <= 4; k++) wr(1'b0, 8'(k));
    ce = 1'b1;
    wr(1'b0, 8'h05);
    chk("t7_no_ovf", bus_if.overflow, 1'b0);
    npulse = 0;
    in_pulse = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ctl(0) == 3'b110 && !in_pulse) begin
        npulse++;
        chk("t7_order_da", psg_da, 8'(npulse));
      end
      in_pulse = (ctl(0) == 3'b110);
      tick();
    end
    chk("t7_pulses", npulse, 5);
    chk("t7_busy_end", bus_if.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psg_bus_bridge.md
PSG_BUS_BRIDGE -- requirements
Module: psg_bus_bridge

Interface
REQ-001 SHALL have parameter NUM_CHIPS, default 2, number of PSG cores driven (1..4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, write-queue entries (power of 2, >=2).
REQ-003 SHALL have parameter SOUND_W, default 10, mixed audio width (8..12).
REQ-004 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-006 SHALL have ports ce  in  1  PSG clock enable; address  in  1  0=data port, 1=address port; data  in  8  CPU write data; wren  in  1  one-cycle write strobe; rden  in  1  read strobe.
REQ-007 SHALL have ports q  out  8  read data; busy  out  1  queue non-empty or FSM not IDLE; overflow  out  1  sticky lost-write flag.
REQ-008 SHALL have ports psg_da  out  8  data to all cores; psg_bdir, psg_bc2, psg_bc1  out  NUM_CHIPS each  per-core bus control.
REQ-009 SHALL have ports psg_q  in  8*NUM_CHIPS  core read data; psg_q_oe_l  in  NUM_CHIPS  core output enable, active low; psg_sound  in  8*NUM_CHIPS  core audio; sound  out  SOUND_W  mixed audio.

Function
REQ-010 SHALL push {address,data} into the FIFO on every clk with wren=1 and FIFO not full.
REQ-011 SHALL drop a write arriving with FIFO full and set overflow; overflow SHALL stay set until reset.
REQ-012 SHALL support push and pop in the same cycle, occupancy unchanged, including at full.
REQ-013 SHALL run FSM IDLE -> DRIVE -> GAP -> IDLE; IDLE pops the head entry when FIFO non-empty and ce=1.
REQ-014 SHALL treat a popped address-port entry with data >= 8'h100-NUM_CHIPS as chip select (8'hFF=chip0, 8'hFE=chip1, ...): update sel, assert no control, return to IDLE next cycle.
REQ-015 SHALL in DRIVE present psg_da=entry data and, on core sel only, {bdir,bc2,bc1}=001 for address-port entries and 110 for data-port entries; all other cores 000.
REQ-016 SHALL hold DRIVE until the first clk with ce=1, then enter GAP with all controls 000; GAP SHALL exit to IDLE on the next clk with ce=1.
REQ-017 SHALL therefore keep every control pulse active across exactly one ce-qualified edge, separated by at least one idle ce edge.
REQ-018 SHALL on rden=1 with FSM IDLE and FIFO empty drive {bdir,bc2,bc1}=011 on core sel in the same cycle, and register q <= psg_q[sel] on that edge if psg_q_oe_l[sel]=0, else q holds.
REQ-019 SHALL ignore rden while busy=1: no read control asserted, q holds its previous value.
REQ-020 SHALL drive psg_da=8'h00 whenever no write is driven.
REQ-021 SHALL register sound every clk as the unsigned sum of all psg_sound bytes, saturated to 2^SOUND_W-1.
REQ-022 SHALL give a write queued into an empty FIFO at cycle t its DRIVE state no earlier than t+1.

Reset
REQ-023 SHALL on reset_n=0 at a clk edge empty the FIFO, set FSM IDLE, sel=0, overflow=0, q=8'hFF, sound=0, all psg controls 000, psg_da=8'h00.
REQ-024 SHALL abandon an in-flight DRIVE on reset, deasserting controls on that same edge; queued entries are discarded.
REQ-025 SHALL ignore wren and rden during reset.

Configuration
REQ-026 SHALL with macro PSG_BRIDGE_READBACK_EN defined implement REQ-018/REQ-019.
REQ-027 SHALL with PSG_BRIDGE_READBACK_EN undefined hold q at 8'hFF, never assert 011, and ignore psg_q and psg_q_oe_l.

Verification
REQ-028 SHALL cover: ce=1 continuously, write addr 8'h07 then data 8'h38 -> chip0 sees 001 with da=07, one GAP, then 110 with da=38.
REQ-029 SHALL cover: write addr 8'hFE, addr 8'h08, data 8'h0F -> only chip1 controls toggle; chip0 stays 000.
REQ-030 SHALL cover: ce pulsing 1-in-8, five back-to-back writes with FIFO_DEPTH=4 -> four serviced in order, overflow=1, busy falls after last GAP.
REQ-031 SHALL cover: readback enabled, idle, rden with psg_q[chip0]=8'h5A, oe_l=0 -> 011 asserted that cycle, q=8'h5A next cycle; rden while busy -> q unchanged.
REQ-032 SHALL cover: NUM_CHIPS=2, SOUND_W=8, psg_sound 8'hC0 and 8'h80 -> sound=8'hFF; reset mid-DRIVE -> controls 000 and busy=0 on the reset edge.
